// File: rtl/rob.sv
// Reorder buffer: multi-issue allocation, multi-port completion, in-order
// multi-slot retirement with mispredict flush.
module rob #(
    parameter int ISSUE_WIDTH_MAX = 2,
    parameter int ROB_MAX_RETIRE  = 2,
    parameter int ROB_SIZE        = 32,
    parameter int CMPL_PORTS      = 2,
    parameter int SRC_LEN         = 5,
    parameter int OPCODE_LEN      = 7,
    parameter int ROB_SIZE_CLOG   = $clog2(ROB_SIZE)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [ISSUE_WIDTH_MAX-1:0]                    instr_val_id,
    input  logic [ISSUE_WIDTH_MAX-1:0][OPCODE_LEN-1:0]    opcode_id,
    input  logic [ISSUE_WIDTH_MAX-1:0][SRC_LEN-1:0]       rd_id,
    input  logic [CMPL_PORTS-1:0]                         cmpl_val,
    input  logic [CMPL_PORTS-1:0][ROB_SIZE_CLOG-1:0]      cmpl_robid,
    input  logic [CMPL_PORTS-1:0]                         cmpl_mispredict,
    output logic [ROB_SIZE_CLOG-1:0]                      rob_is_ptr,
    output logic                                          rob_full,
    output logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0]        rd_ret,
    output logic [ROB_MAX_RETIRE-1:0]                     val_ret,
    output logic [ROB_MAX_RETIRE-1:0]                     branch_ret,
    output logic                                          branch_clear_id,
    output logic [ROB_SIZE_CLOG-1:0]                      mispredict_tag_id
);

    localparam int CW = ROB_SIZE_CLOG + 1;
    localparam logic [OPCODE_LEN-1:0] S_TYPE  = OPCODE_LEN'(7'b0100011);
    localparam logic [OPCODE_LEN-1:0] SB_TYPE = OPCODE_LEN'(7'b1100011);

    // Stores and branches never write a destination register.
    function automatic logic is_no_rd(input logic [OPCODE_LEN-1:0] op);
        return (op == S_TYPE) | (op == SB_TYPE);
    endfunction

    logic [ROB_SIZE-1:0]      valid_q, valid_d, done_q, done_d;
    logic [ROB_SIZE-1:0]      mp_q, mp_d, no_rd_q, no_rd_d;
    logic [SRC_LEN-1:0]       rd_q [ROB_SIZE];
    logic [SRC_LEN-1:0]       rd_d [ROB_SIZE];
    logic [ROB_SIZE_CLOG-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;

    logic [ROB_MAX_RETIRE-1:0][SRC_LEN-1:0] rd_ret_q, rd_ret_d;
    logic [ROB_MAX_RETIRE-1:0]              val_ret_q, branch_ret_q, branch_ret_d;
    logic                                   clear_q;
    logic [ROB_SIZE_CLOG-1:0]               tag_q, tag_d;

    logic [ISSUE_WIDTH_MAX-1:0]                    alloc_s;
    logic [ISSUE_WIDTH_MAX-1:0][ROB_SIZE_CLOG-1:0] alloc_id_s;
    logic [CW-1:0]                                 alloc_cnt_s;
    logic [ROB_MAX_RETIRE-1:0]                     ret_s;
    logic [ROB_MAX_RETIRE-1:0][ROB_SIZE_CLOG-1:0]  ret_id_s;
    logic [CW-1:0]                                 ret_cnt_s;
    logic                                          flush_s;
    logic [ROB_SIZE_CLOG-1:0]                      flush_id_s;
    logic                                          chain_s;

    assign rob_is_ptr        = tail_q;
    assign rob_full          = (CW'(ROB_SIZE) - count_q) < CW'(ISSUE_WIDTH_MAX);
    assign rd_ret            = rd_ret_q;
    assign val_ret           = val_ret_q;
    assign branch_ret        = branch_ret_q;
    assign branch_clear_id   = clear_q;
    assign mispredict_tag_id = tag_q;

    // Slot-ordered allocation: each allocating slot takes the next free robid.
    always_comb begin
        alloc_cnt_s = '0;
        for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
            alloc_s[i]    = instr_val_id[i] & ~rob_full;
            alloc_id_s[i] = tail_q + alloc_cnt_s[ROB_SIZE_CLOG-1:0];
            alloc_cnt_s   = alloc_cnt_s + CW'(alloc_s[i]);
        end
    end

    // In-order retire chain; a retiring mispredicted entry ends the chain.
    always_comb begin
        ret_cnt_s  = '0;
        flush_s    = 1'b0;
        flush_id_s = '0;
        chain_s    = 1'b1;
        for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
            ret_id_s[k] = head_q + ROB_SIZE_CLOG'(k);
            ret_s[k]    = chain_s & valid_q[ret_id_s[k]] & done_q[ret_id_s[k]];
            ret_cnt_s   = ret_cnt_s + CW'(ret_s[k]);
            flush_id_s  = (ret_s[k] & mp_q[ret_id_s[k]] & ~flush_s) ? ret_id_s[k] : flush_id_s;
            flush_s     = flush_s | (ret_s[k] & mp_q[ret_id_s[k]]);
            chain_s     = ret_s[k] & ~mp_q[ret_id_s[k]];
        end
    end

    // Per-entry next state: completion, retirement, allocation, flush.
    always_comb begin : entry_next
        logic c_hit, c_mp, r_hit, a_hit, a_nord, sel;
        logic [SRC_LEN-1:0] a_rd;
        for (int e = 0; e < ROB_SIZE; e++) begin
            c_hit  = 1'b0;
            c_mp   = 1'b0;
            r_hit  = 1'b0;
            a_hit  = 1'b0;
            a_nord = 1'b0;
            a_rd   = '0;
            sel    = 1'b0;
            for (int p = 0; p < CMPL_PORTS; p++) begin
                sel   = cmpl_val[p] & (cmpl_robid[p] == ROB_SIZE_CLOG'(e));
                c_hit = c_hit | sel;
                c_mp  = c_mp | (sel & cmpl_mispredict[p]);
            end
            for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
                r_hit = r_hit | (ret_s[k] & (ret_id_s[k] == ROB_SIZE_CLOG'(e)));
            end
            for (int i = 0; i < ISSUE_WIDTH_MAX; i++) begin
                sel    = alloc_s[i] & (alloc_id_s[i] == ROB_SIZE_CLOG'(e));
                a_hit  = a_hit | sel;
                a_rd   = sel ? rd_id[i] : a_rd;
                a_nord = sel ? is_no_rd(opcode_id[i]) : a_nord;
            end
            c_hit = c_hit & valid_q[e];
            if (flush_s) begin
                valid_d[e] = 1'b0;
                done_d[e]  = 1'b0;
                mp_d[e]    = 1'b0;
                no_rd_d[e] = no_rd_q[e];
                rd_d[e]    = rd_q[e];
            end else begin
                valid_d[e] = a_hit | (valid_q[e] & ~r_hit);
                done_d[e]  = ~a_hit & (done_q[e] | c_hit);
                mp_d[e]    = ~a_hit & (mp_q[e] | (c_hit & c_mp));
                no_rd_d[e] = a_hit ? a_nord : no_rd_q[e];
                rd_d[e]    = a_hit ? a_rd : rd_q[e];
            end
        end
    end

    // Pointers, occupancy and retire-output next state.
    always_comb begin
        if (flush_s) begin
            head_d  = flush_id_s + ROB_SIZE_CLOG'(1);
            tail_d  = flush_id_s + ROB_SIZE_CLOG'(1);
            count_d = '0;
            tag_d   = flush_id_s;
        end else begin
            head_d  = head_q + ret_cnt_s[ROB_SIZE_CLOG-1:0];
            tail_d  = tail_q + alloc_cnt_s[ROB_SIZE_CLOG-1:0];
            count_d = count_q + alloc_cnt_s - ret_cnt_s;
            tag_d   = tag_q;
        end
        for (int k = 0; k < ROB_MAX_RETIRE; k++) begin
            rd_ret_d[k]     = ret_s[k] ? rd_q[ret_id_s[k]] : '0;
            branch_ret_d[k] = ret_s[k] & no_rd_q[ret_id_s[k]];
        end
    end

    // Control state and registered retire outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            done_q       <= '0;
            mp_q         <= '0;
            no_rd_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rd_ret_q     <= '0;
            val_ret_q    <= '0;
            branch_ret_q <= '0;
            clear_q      <= 1'b0;
            tag_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            done_q       <= done_d;
            mp_q         <= mp_d;
            no_rd_q      <= no_rd_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            rd_ret_q     <= rd_ret_d;
            val_ret_q    <= ret_s;
            branch_ret_q <= branch_ret_d;
            clear_q      <= flush_s;
            tag_q        <= tag_d;
        end
    end

    // Destination payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        rd_q <= rd_d;
    end

endmodule
